// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the RV32 data memory load/store unit:
//   - RV32 load/store funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - response error codes (dmem_err_e)
//   - control FSM states (dmem_state_e)
//   - dmem_check(): classifies a request as ok / misaligned / illegal
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10
    } dmem_err_e;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } dmem_state_e;

    // An illegal funct3 wins over misalignment, because the access size is
    // meaningless when the encoding itself is not a valid load or store.
    // funct3[1:0] carries the access size for every legal encoding.
    function automatic dmem_err_e dmem_check(input logic       we,
                                             input logic [2:0] funct3,
                                             input logic [1:0] offset);
        logic legal;
        if (we) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        if (!legal) begin
            return ERR_ILLEGAL;
        end else if ((funct3[1:0] == 2'b01 && offset[0]) ||
                     (funct3[1:0] == 2'b10 && offset != 2'b00)) begin
            return ERR_MISALIGN;
        end else begin
            return ERR_NONE;
        end
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for the RV32 data memory.
// Store side: turns {funct3, byte offset, right-aligned data} into per-lane
// byte enables plus data replicated across the lanes.
// Load side: turns {funct3, byte offset, stored word} into the extracted and
// sign/zero-extended load value (little-endian).
// Ports:
//   st_funct3_i, st_offset_i, st_wdata_i : store request fields
//   st_be_o, st_wdata_o                  : byte enables and replicated data
//   ld_funct3_i, ld_offset_i, ld_word_i  : registered load fields
//   ld_data_o                            : extended load result
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_offset_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_offset_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ldShifted;

    // Store steering: the data is replicated into every lane, so the byte
    // enables alone decide which lanes actually land in the array.
    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = 32'h0;
        case (st_funct3_i)
            F3_B: begin
                st_be_o    = 4'b0001 << st_offset_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            F3_H: begin
                st_be_o    = st_offset_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            F3_W: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_wdata_i;
            end
            default: begin
                st_be_o    = 4'b0000;
                st_wdata_o = 32'h0;
            end
        endcase
    end

    // Load steering: shift the addressed byte down to bit 0, then extend.
    // Legal word loads always have offset 0, so the shift is a no-op there.
    always_comb begin
        ldShifted = ld_word_i >> {ld_offset_i, 3'b000};
        ld_data_o = 32'h0;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ldShifted[7]}}, ldShifted[7:0]};
            F3_BU:   ld_data_o = {24'h0, ldShifted[7:0]};
            F3_H:    ld_data_o = {{16{ldShifted[15]}}, ldShifted[15:0]};
            F3_HU:   ld_data_o = {16'h0, ldShifted[15:0]};
            F3_W:    ld_data_o = ldShifted;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_rv.sv
// -----------------------------------------------------------------------------
// data_memory_rv
// Pipelined, byte-addressed RV32 load/store unit backed by a word array.
// Sits in the MEM stage between the ALU result and the writeback mux.
// A request is accepted on req_valid && req_ready; its response (load data,
// error code) appears as a one-cycle rsp_valid pulse in the following cycle.
// After reset an optional sweep zeroes every entry before requests are taken.
// Parameters: ADDR_WIDTH (log2 word entries), DATA_WIDTH (must be 32),
//             CLEAR_ON_RESET (1 = zero the array after reset).
// Ports:
//   clk, rst (synchronous, active high)
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//   rsp_valid/rsp_rdata/rsp_err                             : response
//   init_done                                               : sweep complete
//   perf_loads/perf_stores/perf_faults : only with DMEM_PERF_CNT_EN defined
// Optional feature macro: DMEM_PERF_CNT_EN
// -----------------------------------------------------------------------------
module data_memory_rv
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_err,
    output logic                    init_done
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]             perf_loads,
    output logic [31:0]             perf_stores,
    output logic [31:0]             perf_faults
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("data_memory_rv: only DATA_WIDTH = 32 is supported");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    dmem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clrCnt_q, clrCnt_d;
    logic                  initDone_q, initDone_d;

    logic                  rspValid_q;
    logic                  rspWe_q;
    logic [2:0]            rspFunct3_q;
    logic [1:0]            rspOffset_q;
    dmem_err_e             rspErr_q;
    logic [DATA_WIDTH-1:0] rdWord_q;

    logic                  accept;
    dmem_err_e             reqErr;
    logic [ADDR_WIDTH-1:0] reqIdx;
    logic                  storeWrite;
    logic [3:0]            stBe;
    logic [DATA_WIDTH-1:0] stWdata;
    logic [DATA_WIDTH-1:0] ldData;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid && req_ready && !rst;
    assign reqErr     = dmem_check(req_we, req_funct3, req_addr[1:0]);
    assign reqIdx     = req_addr[ADDR_WIDTH+1:2];
    assign storeWrite = accept && req_we && (reqErr == ERR_NONE);

    dmem_lane_align u_align (
        .st_funct3_i (req_funct3),
        .st_offset_i (req_addr[1:0]),
        .st_wdata_i  (req_wdata),
        .st_be_o     (stBe),
        .st_wdata_o  (stWdata),
        .ld_funct3_i (rspFunct3_q),
        .ld_offset_i (rspOffset_q),
        .ld_word_i   (rdWord_q),
        .ld_data_o   (ldData)
    );

    // Sweep sequencing: CLEAR walks the counter once over every entry and
    // hands over to IDLE after the last one; init_done rises with IDLE.
    always_comb begin
        state_d    = state_q;
        clrCnt_d   = clrCnt_q;
        initDone_d = initDone_q;
        case (state_q)
            CLEAR: begin
                clrCnt_d = clrCnt_q + 1'b1;
                if (clrCnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d    = IDLE;
                    initDone_d = 1'b1;
                end
            end
            IDLE: begin
                initDone_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers. Reset restarts the sweep from entry 0
    // no matter where it was interrupted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clrCnt_q    <= '0;
            initDone_q  <= 1'b0;
            rspValid_q  <= 1'b0;
            rspWe_q     <= 1'b0;
            rspFunct3_q <= 3'b000;
            rspOffset_q <= 2'b00;
            rspErr_q    <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            clrCnt_q   <= clrCnt_d;
            initDone_q <= initDone_d;
            rspValid_q <= accept;
            if (accept) begin
                rspWe_q     <= req_we;
                rspFunct3_q <= req_funct3;
                rspOffset_q <= req_addr[1:0];
                rspErr_q    <= reqErr;
            end
        end
    end

    // Array port: the sweep and stores share the write side. The read is
    // read-first, so a load sees every write from earlier edges but not a
    // write on its own edge (which cannot happen since only one request is
    // accepted per edge).
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clrCnt_q] <= '0;
        end else if (storeWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (stBe[b]) begin
                    mem[reqIdx][8*b +: 8] <= stWdata[8*b +: 8];
                end
            end
        end
        if (accept) begin
            rdWord_q <= mem[reqIdx];
        end
    end

    // Stores and faulted loads return zero data; the error code is only
    // presented while the response is valid.
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = (rspValid_q && !rspWe_q && rspErr_q == ERR_NONE) ? ldData : '0;
    assign rsp_err   = rspValid_q ? rspErr_q : ERR_NONE;
    assign init_done = initDone_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perfLoads_q, perfStores_q, perfFaults_q;

    // Every accepted request lands in exactly one class; faults are not
    // counted as loads or stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfLoads_q  <= 32'h0;
            perfStores_q <= 32'h0;
            perfFaults_q <= 32'h0;
        end else if (accept) begin
            if (reqErr != ERR_NONE) begin
                perfFaults_q <= perfFaults_q + 32'h1;
            end else if (req_we) begin
                perfStores_q <= perfStores_q + 32'h1;
            end else begin
                perfLoads_q <= perfLoads_q + 32'h1;
            end
        end
    end

    assign perf_loads  = perfLoads_q;
    assign perf_stores = perfStores_q;
    assign perf_faults = perfFaults_q;
`endif

endmodule

// File: tb/tb_data_memory_rv.sv
// -----------------------------------------------------------------------------
// tb_data_memory_rv
// Directed testbench for data_memory_rv with ADDR_WIDTH=4 (16 words) and the
// clear sweep enabled. Each scenario task drives its own vectors and compares
// against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_data_memory_rv;

    localparam int AW = 4;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic [31:0] expData;
        logic [1:0]  expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        init_done;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_faults;
`endif

    int compared   = 0;
    int mismatched = 0;
    int expLoads   = 0;
    int expStores  = 0;
    int expFaults  = 0;

    always #5 clk = ~clk;

    data_memory_rv #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .CLEAR_ON_RESET(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_done  (init_done)
`ifdef DMEM_PERF_CNT_EN
        ,
        .perf_loads (perf_loads),
        .perf_stores(perf_stores),
        .perf_faults(perf_faults)
`endif
    );

    // Drives one request for a single edge; called #1 after a rising edge and
    // returns #1 after the next one, which is the response cycle.
    task automatic issue(input vec_t v);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
    endtask

    // Bookkeeping for the optional performance counters.
    task automatic tally(input vec_t v);
        if (v.expErr != 2'b00) expFaults++;
        else if (v.we)         expStores++;
        else                   expLoads++;
    endtask

    // Counts cycles with req_ready low after a reset edge, bounded.
    task automatic waitSweep(output int cycles);
        cycles = 1;
        rst = 1'b0;
        while (req_ready !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            if (req_ready !== 1'b1) cycles++;
        end
    endtask

    task automatic test_reset();
        int cycles;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.rsp_valid got %0b want 0", rsp_valid); end
        compared++;
        if (rsp_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset.rsp_rdata got %h want 0", rsp_rdata); end
        compared++;
        if (rsp_err !== 2'b00) begin mismatched++; $display("[TB] FAIL reset.rsp_err got %b want 00", rsp_err); end
        compared++;
        if (init_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.init_done got %0b want 0", init_done); end
        compared++;
        if (req_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.req_ready got %0b want 0", req_ready); end
        waitSweep(cycles);
        compared++;
        if (cycles != 16) begin mismatched++; $display("[TB] FAIL reset.sweep_len got %0d want 16", cycles); end
        compared++;
        if (init_done !== 1'b1) begin mismatched++; $display("[TB] FAIL reset.init_done_after got %0b want 1", init_done); end
    endtask

    task automatic test_load_store();
        vec_t v[11];
        v[0]  = '{1'b1, 3'b010, 6'h10, 32'hDEADBEEF, 32'h00000000, 2'b00};
        v[1]  = '{1'b1, 3'b000, 6'h11, 32'h00000080, 32'h00000000, 2'b00};
        v[2]  = '{1'b0, 3'b000, 6'h11, 32'h0,        32'hFFFFFF80, 2'b00};
        v[3]  = '{1'b0, 3'b100, 6'h11, 32'h0,        32'h00000080, 2'b00};
        v[4]  = '{1'b0, 3'b010, 6'h10, 32'h0,        32'hDEAD80EF, 2'b00};
        v[5]  = '{1'b0, 3'b001, 6'h12, 32'h0,        32'hFFFFDEAD, 2'b00};
        v[6]  = '{1'b0, 3'b000, 6'h13, 32'h0,        32'hFFFFFFDE, 2'b00};
        v[7]  = '{1'b1, 3'b001, 6'h22, 32'h00001234, 32'h00000000, 2'b00};
        v[8]  = '{1'b0, 3'b001, 6'h22, 32'h0,        32'h00001234, 2'b00};
        v[9]  = '{1'b0, 3'b101, 6'h20, 32'h0,        32'h00000000, 2'b00};
        v[10] = '{1'b0, 3'b010, 6'h3C, 32'h0,        32'h00000000, 2'b00};
        for (int i = 0; i < 11; i++) begin
            issue(v[i]);
            tally(v[i]);
            compared++;
            if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ldst[%0d].rsp_valid got %0b want 1", i, rsp_valid); end
            compared++;
            if (rsp_rdata !== v[i].expData) begin mismatched++; $display("[TB] FAIL ldst[%0d].rsp_rdata got %h want %h", i, rsp_rdata, v[i].expData); end
            compared++;
            if (rsp_err !== v[i].expErr) begin mismatched++; $display("[TB] FAIL ldst[%0d].rsp_err got %b want %b", i, rsp_err, v[i].expErr); end
        end
    endtask

    task automatic test_faults();
        vec_t v[8];
        v[0] = '{1'b0, 3'b010, 6'h13, 32'h0,        32'h00000000, 2'b01};
        v[1] = '{1'b1, 3'b001, 6'h21, 32'h0000ABCD, 32'h00000000, 2'b01};
        v[2] = '{1'b0, 3'b010, 6'h20, 32'h0,        32'h12340000, 2'b00};
        v[3] = '{1'b0, 3'b011, 6'h20, 32'h0,        32'h00000000, 2'b10};
        v[4] = '{1'b1, 3'b011, 6'h20, 32'hFFFFFFFF, 32'h00000000, 2'b10};
        v[5] = '{1'b0, 3'b010, 6'h20, 32'h0,        32'h12340000, 2'b00};
        v[6] = '{1'b0, 3'b110, 6'h21, 32'h0,        32'h00000000, 2'b10};
        v[7] = '{1'b0, 3'b101, 6'h23, 32'h0,        32'h00000000, 2'b01};
        for (int i = 0; i < 8; i++) begin
            issue(v[i]);
            tally(v[i]);
            compared++;
            if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL fault[%0d].rsp_valid got %0b want 1", i, rsp_valid); end
            compared++;
            if (rsp_rdata !== v[i].expData) begin mismatched++; $display("[TB] FAIL fault[%0d].rsp_rdata got %h want %h", i, rsp_rdata, v[i].expData); end
            compared++;
            if (rsp_err !== v[i].expErr) begin mismatched++; $display("[TB] FAIL fault[%0d].rsp_err got %b want %b", i, rsp_err, v[i].expErr); end
        end
        @(posedge clk);
        #1;
        compared++;
        if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fault.pulse_end got %0b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        vec_t st, ld;
        st = '{1'b1, 3'b010, 6'h00, 32'h11111111, 32'h00000000, 2'b00};
        ld = '{1'b0, 3'b010, 6'h00, 32'h0,        32'h11111111, 2'b00};
        issue(st);
        tally(st);
        compared++;
        if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b.store_valid got %0b want 1", rsp_valid); end
        issue(ld);
        tally(ld);
        compared++;
        if (rsp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b.load_valid got %0b want 1", rsp_valid); end
        compared++;
        if (rsp_rdata !== 32'h11111111) begin mismatched++; $display("[TB] FAIL b2b.load_data got %h want 11111111", rsp_rdata); end
    endtask

`ifdef DMEM_PERF_CNT_EN
    task automatic test_perf();
        compared++;
        if (perf_loads !== 32'(expLoads)) begin mismatched++; $display("[TB] FAIL perf.loads got %0d want %0d", perf_loads, expLoads); end
        compared++;
        if (perf_stores !== 32'(expStores)) begin mismatched++; $display("[TB] FAIL perf.stores got %0d want %0d", perf_stores, expStores); end
        compared++;
        if (perf_faults !== 32'(expFaults)) begin mismatched++; $display("[TB] FAIL perf.faults got %0d want %0d", perf_faults, expFaults); end
    endtask
`endif

    task automatic test_mid_sweep_reset();
        int   cycles;
        vec_t ign, chk;
        ign = '{1'b1, 3'b010, 6'h00, 32'hCAFEF00D, 32'h0, 2'b00};
        chk = '{1'b0, 3'b010, 6'h00, 32'h0,        32'h0, 2'b00};
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        issue(ign);
        compared++;
        if (rsp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst.ignored_valid got %0b want 0", rsp_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (init_done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst.init_done got %0b want 0", init_done); end
        waitSweep(cycles);
        compared++;
        if (cycles != 16) begin mismatched++; $display("[TB] FAIL midrst.sweep_len got %0d want 16", cycles); end
        issue(chk);
        compared++;
        if (rsp_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst.cleared_word got %h want 0", rsp_rdata); end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_faults();
        test_back_to_back();
`ifdef DMEM_PERF_CNT_EN
        test_perf();
`endif
        test_mid_sweep_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_memory_rv.md
Name: data_memory_rv

Overview:
- Next-generation data memory for the RISC-V core; the single-cycle, word-only RAM becomes a pipelined, byte-addressed RV32 load/store unit backed by a parametrised word array.
- Decodes RV32 load/store funct3 (byte/half/word, signed/unsigned) and writes with per-byte lane enables.
- Registered read with a valid/ready request and a one-cycle response; flags misaligned and illegal accesses.
- Performs a hardware clear sweep after reset. Sits in the MEM stage between the ALU result and the writeback mux.

Parameters:
- ADDR_WIDTH, 10, log2 of word entries (array depth = 1<<ADDR_WIDTH words).
- DATA_WIDTH, 32, word width; only 32 is supported (RV32); elaboration error otherwise.
- CLEAR_ON_RESET, 1, 1 = zero every entry after reset; 0 = skip the sweep.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 funct3 of the load/store.
- req_addr  input  ADDR_WIDTH+2  byte address; [1:0] = byte offset, [ADDR_WIDTH+1:2] = word index.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and faults.
- rsp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3.
- init_done  output  1  clear sweep complete.

Behaviour:
- Reset (rst=1 at an edge): rsp_valid=0, rsp_rdata=0, rsp_err=00, init_done=0, FSM→CLEAR (CLEAR_ON_RESET=1) or IDLE (0), clear counter=0. Array contents are not reset directly.
- FSM states:
  - CLEAR: writes 0 to entry[counter] each cycle; counter increments. After entry (1<<ADDR_WIDTH)-1 is written → IDLE, init_done=1 on the next cycle.
  - Sweep length is exactly 1<<ADDR_WIDTH cycles. req_ready=0 throughout.
  - IDLE: req_ready=1. With CLEAR_ON_RESET=0, init_done=1 from the first cycle after reset release.
- rst asserted mid-sweep restarts the sweep from entry 0.
- Latency: a request accepted at edge N gives rsp_valid=1 for exactly the cycle after N, for stores as well as loads. A request accepted at every edge is sustained at 1/cycle. No response backpressure.
- Load funct3:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: word.
  - 100 LBU, 101 LHU: zero-extended.
  - 011, 110, 111: illegal.
- Store funct3:
  - 000 SB: lane enable = 1 << addr[1:0]; wdata[7:0] is replicated to all lanes.
  - 001 SH: lanes {addr[1],addr[1]} pair; wdata[15:0] is replicated.
  - 010 SW: all lanes.
  - Any other value: illegal.
- Byte selection uses addr[1:0]; little-endian.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠00 → rsp_err=01. Checked only when funct3 is legal; illegal takes priority (10).
- Faulted stores write nothing. Faulted loads return rsp_rdata=0. A fault still produces a normal rsp_valid pulse.
- The array is read synchronously at the accept edge, old data (read-first). Alignment/extension of the registered word happens combinationally in the response cycle, so the response reflects all earlier writes.
- Requests while req_ready=0 are ignored; they produce no write and no response.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- Defined: adds outputs perf_loads, perf_stores, perf_faults (32 bits each). Each counts accepted requests of its class; faults count only in perf_faults. All reset to 0 and wrap modulo 2^32.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - rsp_err enum (ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL).
  - FSM state enum (CLEAR, IDLE).
- Sub-module dmem_lane_align: combinational; produces store byte-enables and replicated write data, plus load extract/extend from {funct3, offset, word}. Shared by both paths.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4 → req_ready=0 for exactly 16 cycles, then init_done=1; LW at 0x3C returns 0x00000000.
- SW 0xDEADBEEF @0x10; SB 0x80 @0x11; LB @0x11 → 0xFFFFFF80; LBU @0x11 → 0x00000080; LW @0x10 → 0xDEAD80EF.
- SH 0x1234 @0x22; LH @0x22 → 0x00001234; LHU @0x20 → 0x00000000 (lower half untouched).
- LW @0x13 → rsp_err=01, rdata=0. SH @0x21 → rsp_err=01, then LW @0x20 is unchanged. Load funct3=011 → rsp_err=10.
- Back-to-back: SW 0x11111111 @0x0 at edge N, LW @0x0 at edge N+1 → load response at N+2 = 0x11111111; rsp_valid high for both consecutive cycles.
- rst pulsed at sweep cycle 5 → sweep restarts, full 16 cycles before init_done. With DMEM_PERF_CNT_EN, after the above sequence, counters match the accepted load/store/fault totals.
